// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake into an
// output slot backed by a one-entry skid buffer, and redirects on taken branches.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pc_write,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] npc_if,
   output logic [31:0] instruction_if,
   output logic        if_valid
);

   typedef enum logic {IDLE, PEND} state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] drop_addr;
   logic [31:0] out_npc;
   logic [31:0] out_instr;
   logic [31:0] skid_npc;
   logic [31:0] skid_instr;
   logic        out_valid;
   logic        skid_valid;
   logic        skid_valid_next;
   logic        drop;

   logic        ack_seen;
   logic        accept;
   logic        consume;
   logic        to_out;

   assign ack_seen = (state == PEND) && imem_ack;
   assign accept   = ack_seen && !drop && !branch_taken;
   assign consume  = pc_write && out_valid && !branch_taken;
   assign to_out   = !out_valid || pc_write;
   assign pc_plus4 = pc + 32'd4;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      skid_valid_next = skid_valid;
      if (branch_taken) begin
         skid_valid_next = 1'b0;
      end else if (accept && !to_out) begin
         skid_valid_next = 1'b1;
      end else if (consume && skid_valid) begin
         skid_valid_next = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A request is only launched once the skid buffer is guaranteed empty, so at most
   // two instructions are ever buffered and only one request is outstanding.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (branch_taken || !skid_valid_next) state_next = PEND;
         PEND: if (accept && !to_out) state_next = IDLE;
      endcase
   end

   always_comb begin
      imem_req       = (state == PEND);
      imem_addr      = drop ? drop_addr : pc;
      instruction_if = out_valid ? out_instr : NOP_INSTR;
      npc_if         = out_npc;
      if_valid       = out_valid;
   end

   // NOTE: skid payload and drop_addr are qualified by their valid/drop flags, so they carry no reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pc         <= RESET_PC;
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         drop       <= 1'b0;
         out_npc    <= 32'd0;
         out_instr  <= NOP_INSTR;
      end else if (branch_taken) begin
         pc         <= branch_target;
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         // The in-flight request keeps its original address until memory answers it.
         if ((state == PEND) && !imem_ack) begin
            if (!drop) drop_addr <= pc;
            drop <= 1'b1;
         end else begin
            drop <= 1'b0;
         end
      end else begin
         if (ack_seen && drop) drop <= 1'b0;
         if (accept) begin
            pc <= pc_plus4;
            if (to_out) begin
               out_npc   <= pc_plus4;
               out_instr <= imem_rdata;
               out_valid <= 1'b1;
            end else begin
               skid_npc   <= pc_plus4;
               skid_instr <= imem_rdata;
               skid_valid <= 1'b1;
            end
         end else if (consume) begin
            if (skid_valid) begin
               out_npc    <= skid_npc;
               out_instr  <= skid_instr;
               skid_valid <= 1'b0;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed vector table for the listed corner cases,
// then randomized traffic checked against a queue-based behavioural model.
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] TAG      = 32'hA5A5_0000;

   logic        clock;
   logic        reset;
   logic        pc_write;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] npc_if;
   logic [31:0] instruction_if;
   logic        if_valid;

   if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clock          (clock),
      .reset          (reset),
      .pc_write       (pc_write),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .npc_if         (npc_if),
      .instruction_if (instruction_if),
      .if_valid       (if_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: buffered instructions are a FIFO of at most two entries.
   typedef struct {
      logic [31:0] npc;
      logic [31:0] instr;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc;
   logic        m_pend;
   logic        m_drop;
   logic [31:0] m_daddr;
   logic [31:0] m_last_npc;

   task automatic model_reset();
      m_q.delete();
      m_pc       = RESET_PC;
      m_pend     = 1'b0;
      m_drop     = 1'b0;
      m_daddr    = 32'd0;
      m_last_npc = 32'd0;
   endtask

   task automatic model_step(input logic r, input logic pw, input logic bt,
                             input logic [31:0] tg, input logic ack, input logic [31:0] rd);
      logic got;
      if (!r) begin
         model_reset();
         return;
      end
      got = m_pend && ack;
      if (bt) begin
         m_q.delete();
         if (m_pend && !ack) begin
            if (!m_drop) m_daddr = m_pc;
            m_drop = 1'b1;
         end else begin
            m_drop = 1'b0;
            m_pend = 1'b1;
         end
         m_pc = tg;
      end else if (got && m_drop) begin
         m_drop = 1'b0;
         if (pw && m_q.size() > 0) void'(m_q.pop_front());
      end else begin
         if (pw && m_q.size() > 0) void'(m_q.pop_front());
         if (got) begin
            m_q.push_back('{m_pc + 32'd4, rd});
            m_pc   = m_pc + 32'd4;
            m_pend = (m_q.size() == 1);
         end else if (!m_pend) begin
            m_pend = (m_q.size() < 2);
         end
      end
      if (m_q.size() > 0) m_last_npc = m_q[0].npc;
   endtask

   task automatic model_check();
      check("m_req", {31'd0, imem_req}, {31'd0, m_pend});
      if (m_pend) check("m_addr", imem_addr, m_drop ? m_daddr : m_pc);
      check("m_valid", {31'd0, if_valid}, {31'd0, (m_q.size() > 0)});
      check("m_instr", instruction_if, (m_q.size() > 0) ? m_q[0].instr : NOP);
      check("m_npc", npc_if, m_last_npc);
   endtask

   // Called at a negedge: drive inputs, check, take one clock edge, return at next negedge.
   task automatic cycle(input logic r, input logic pw, input logic bt,
                        input logic [31:0] tg, input logic ack);
      logic [31:0] a;
      a             = m_drop ? m_daddr : m_pc;
      reset         = r;
      pc_write      = pw;
      branch_taken  = bt;
      branch_target = tg;
      imem_ack      = ack;
      imem_rdata    = ack ? (a ^ TAG) : 32'hDEAD_BEEF;
      model_check();
      @(posedge clock);
      model_step(r, pw, bt, tg, ack, imem_rdata);
      @(negedge clock);
   endtask

   typedef struct {
      logic        rst;
      logic        pw;
      logic        bt;
      logic [31:0] tg;
      logic        ack;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_npc;
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input logic r, input logic pw, input logic bt, input logic [31:0] tg,
                          input logic ack, input logic er, input logic [31:0] ea,
                          input logic ev, input logic [31:0] ei, input logic [31:0] en);
      vq.push_back('{r, pw, bt, tg, ack, er, ea, ev, ei, en});
   endtask

   logic        r_rst;
   logic        r_pw;
   logic        r_bt;
   logic        r_ack;
   logic [31:0] r_tg;
   logic        zero_wait;

   initial begin
      //      rst pw bt target        ack | req addr          valid instr           npc
      // zero-wait streaming
      add_vec(1, 1, 0, 32'h0,         0,    0, 32'h0,         0, NOP,             32'h0);
      add_vec(1, 1, 0, 32'h0,         1,    1, 32'h0,         0, NOP,             32'h0);
      add_vec(1, 1, 0, 32'h0,         1,    1, 32'h4,         1, 32'hA5A5_0000,   32'h4);
      add_vec(1, 1, 0, 32'h0,         1,    1, 32'h8,         1, 32'hA5A5_0004,   32'h8);
      // stall holding @8, skid fills with @12
      add_vec(1, 0, 0, 32'h0,         1,    1, 32'hC,         1, 32'hA5A5_0008,   32'hC);
      add_vec(1, 0, 0, 32'h0,         0,    0, 32'h0,         1, 32'hA5A5_0008,   32'hC);
      add_vec(1, 0, 0, 32'h0,         0,    0, 32'h0,         1, 32'hA5A5_0008,   32'hC);
      add_vec(1, 1, 0, 32'h0,         0,    0, 32'h0,         1, 32'hA5A5_0008,   32'hC);
      add_vec(1, 1, 0, 32'h0,         1,    1, 32'h10,        1, 32'hA5A5_000C,   32'h10);
      // branch to 0x100 in first wait cycle of fetch @20, latency 3
      add_vec(1, 1, 1, 32'h100,       0,    1, 32'h14,        1, 32'hA5A5_0010,   32'h14);
      add_vec(1, 1, 0, 32'h0,         0,    1, 32'h14,        0, NOP,             32'h14);
      add_vec(1, 1, 0, 32'h0,         1,    1, 32'h14,        0, NOP,             32'h14);
      add_vec(1, 1, 0, 32'h0,         0,    1, 32'h100,       0, NOP,             32'h14);
      add_vec(1, 1, 0, 32'h0,         0,    1, 32'h100,       0, NOP,             32'h14);
      add_vec(1, 1, 0, 32'h0,         1,    1, 32'h100,       0, NOP,             32'h14);
      // fill skid under stall, then branch with ack and pw=0
      add_vec(1, 0, 0, 32'h0,         0,    1, 32'h104,       1, 32'hA5A5_0100,   32'h104);
      add_vec(1, 0, 0, 32'h0,         1,    1, 32'h104,       1, 32'hA5A5_0100,   32'h104);
      add_vec(1, 0, 1, 32'h200,       1,    0, 32'h0,         1, 32'hA5A5_0100,   32'h104);
      add_vec(1, 0, 0, 32'h0,         0,    1, 32'h200,       0, NOP,             32'h104);
      // refill out and skid, then reset with late acks
      add_vec(1, 0, 0, 32'h0,         1,    1, 32'h200,       0, NOP,             32'h104);
      add_vec(1, 0, 0, 32'h0,         1,    1, 32'h204,       1, 32'hA5A5_0200,   32'h204);
      add_vec(0, 1, 0, 32'h0,         1,    0, 32'h0,         1, 32'hA5A5_0200,   32'h204);
      add_vec(0, 1, 0, 32'h0,         1,    0, 32'h0,         0, NOP,             32'h0);
      add_vec(1, 1, 0, 32'h0,         1,    0, 32'h0,         0, NOP,             32'h0);
      add_vec(0, 1, 0, 32'h0,         0,    1, 32'h0,         0, NOP,             32'h0);
      add_vec(0, 1, 0, 32'h0,         1,    0, 32'h0,         0, NOP,             32'h0);
      add_vec(1, 1, 0, 32'h0,         0,    0, 32'h0,         0, NOP,             32'h0);
      // wrap: branch to 0xFFFF_FFFC while a fetch of 0 is pending
      add_vec(1, 1, 1, 32'hFFFF_FFFC, 0,    1, 32'h0,         0, NOP,             32'h0);
      add_vec(1, 1, 0, 32'h0,         1,    1, 32'h0,         0, NOP,             32'h0);
      add_vec(1, 1, 0, 32'h0,         1,    1, 32'hFFFF_FFFC, 0, NOP,             32'h0);
      add_vec(1, 1, 0, 32'h0,         0,    1, 32'h0,         1, 32'h5A5A_FFFC,   32'h0);
      add_vec(1, 1, 0, 32'h0,         0,    1, 32'h0,         0, NOP,             32'h0);

      reset         = 1'b0;
      pc_write      = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'd0;
      imem_ack      = 1'b0;
      imem_rdata    = 32'd0;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);

      foreach (vq[i]) begin
         check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vq[i].e_req});
         if (vq[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vq[i].e_addr);
         check($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, vq[i].e_valid});
         check($sformatf("v%0d_instr", i), instruction_if, vq[i].e_instr);
         check($sformatf("v%0d_npc", i), npc_if, vq[i].e_npc);
         cycle(vq[i].rst, vq[i].pw, vq[i].bt, vq[i].tg, vq[i].ack);
      end

      zero_wait = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) zero_wait = ($urandom_range(0, 2) == 0);
         r_rst = ($urandom_range(0, 99) != 0);
         r_pw  = ($urandom_range(0, 9) < 7);
         r_bt  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) r_tg = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
         else r_tg = $urandom() & 32'hFFFF_FFFC;
         r_ack = m_pend && (zero_wait || ($urandom_range(0, 2) == 0));
         cycle(r_rst, r_pw, r_bt, r_tg, r_ack);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
